wb_vmon_msg_assembler: RTL and testbench
========================================

// Module: wb_vmon_msg_assembler
// PURPOSE
//  Sits directly downstream of the Wishbone vmon snoop monitor (mailbox 0x6000_1000).
//  Takes the monitor's stream of captured 32-bit mailbox writes and frames it into
//  messages: one header word followed by payload words.
//  Buffers only complete messages and presents them to the HVL transactor on a
//  valid/ready port. The input has no backpressure because the monitor is passive.
// PARAMETERS
//  DEPTH    64    FIFO entries (33b: data + last flag); power of 2, >= MAX_LEN+1
//  MAX_LEN  16    max payload words per message
//  TIMEOUT  1024  idle cycles before a partial message is aborted (timeout feature only)
// PORTS
//  clk_i      in   1   clock; all logic on posedge
//  rst_n_i    in   1   asynchronous active-low reset
//  in_valid   in   1   monitor captured one mailbox write this cycle
//  in_data    in   32  captured write data
//  out_valid  out  1   FIFO head holds a word of a committed message
//  out_data   out  32  FIFO head data
//  out_last   out  1   head word is the final word of its message
//  out_ready  in   1   consumer accepts head when out_valid&&out_ready
//  busy_o     out  1   assembler state != IDLE
//  drop_cnt   out  16  dropped-message count; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; wr_ptr, cm_ptr, rd_ptr = 0;
//   drop_cnt=0; out_valid=0; busy_o=0; timeout counter=0.
//  Pointers are $clog2(DEPTH)+1 bits and wrap naturally.
//   wr_ptr = speculative write pointer; cm_ptr = commit pointer; rd_ptr = read pointer.
//   free = DEPTH - (wr_ptr - rd_ptr).
//  Header format: len = in_data[15:0] (payload words); in_data[31:16] are opaque.
//  IDLE, in_valid (header):
//   - len > MAX_LEN, or len+1 > free: go to DROP, rem=len, drop_cnt++.
//     If len==0, drop_cnt++ and stay IDLE.
//   - len==0 and fits: write header with last=1; cm_ptr = wr_ptr+1; stay IDLE.
//   - otherwise: write header with last=0; rem=len; go to PAYLOAD.
//   - Space is reserved at the header, so a payload write never overflows.
//     Reads during the message only add free space.
//  PAYLOAD, in_valid: write word with last=(rem==1); rem--.
//   When rem==1, cm_ptr = wr_ptr+1 in the same cycle and go to IDLE.
//  DROP, in_valid: discard word; rem--; when rem==1 go to IDLE. Nothing is written.
//  Output is first-word-fall-through:
//   - out_valid = (rd_ptr != cm_ptr); out_data/out_last are read combinationally at rd_ptr.
//   - Transfer on out_valid&&out_ready advances rd_ptr.
//   - Uncommitted words are never visible.
//   - out_data/out_last hold stable while out_valid&&!out_ready.
//  Simultaneous write and read in one cycle are both honoured. free is evaluated with
//   the pre-cycle rd_ptr, which is conservative.
//  Commit and header-to-visible latency: a committed word is visible on out_valid
//   the cycle after its commit write.
//  The frame boundary is implied only by the header length; the input has no framing side-band.
//  Reset mid-message discards all buffered and partial data.
// CONFIGURATION
//  VMON_MSG_TIMEOUT_EN defined:
//   - In PAYLOAD or DROP, a counter counts cycles with !in_valid and clears on each in_valid.
//   - When it reaches TIMEOUT: wr_ptr = cm_ptr (rollback); drop_cnt++ (only if the state
//     was PAYLOAD, since DROP was already counted); go to IDLE.
//   - The counter is held at 0 in IDLE.
//  VMON_MSG_TIMEOUT_EN undefined: no counter. A partial message waits indefinitely,
//   and the TIMEOUT parameter is unused.
// TESTING
//  1. out_ready=1; send 0x0100_0002, 0xA, 0xB -> out 0x0100_0002, 0xA, 0xB;
//     out_last only on 0xB; drop_cnt=0.
//  2. out_ready=0; send 22 msgs of len 2 -> first 21 (63 words) accepted, 22nd dropped,
//     drop_cnt=1; raising out_ready drains 63 words with 21 last flags.
//  3. Header 0x0000_0000 (len 0) -> single output word with out_last=1; busy_o never set.
//  4. Header len 17 plus 17 words -> none output, drop_cnt=1; a following len-1 msg
//     passes intact.
//  5. rst_n_i low after header and 1 of 3 payload words -> out_valid=0 and drop_cnt=0
//     asynchronously; a post-reset len-2 msg is output intact.
//  6. VMON_MSG_TIMEOUT_EN: header len 4, 2 words, then 1024 idle cycles -> busy_o falls,
//     nothing output, drop_cnt=1; a next len-1 msg is output intact.

Source files
------------

// File: rtl/wb_vmon_msg_assembler.sv
// Frames the vmon snoop-monitor write stream into header+payload messages and
// buffers only complete messages. Optional idle timeout: define VMON_MSG_TIMEOUT_EN.
module wb_vmon_msg_assembler #(
  parameter int DEPTH   = 64,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy_o,
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr;
  logic [15:0]   rem;
  logic [32:0]   mem [DEPTH];

  logic [15:0]   len;
  logic [PW-1:0] used;
  logic [16:0]   free;
  logic          hdr_fits;
  logic          rd_xfer;
  logic          to_hit;

  logic wr_en, wr_last, commit, drop_inc, load_rem, rollback;

  assign len      = in_data[15:0];
  assign used     = wr_ptr - rd_ptr;
  assign free     = 17'(DEPTH) - 17'(used);
  // Header reserves room for the whole message, so payload writes cannot overflow.
  assign hdr_fits = (len <= 16'(MAX_LEN)) && (({1'b0, len} + 17'd1) <= free);

  assign out_valid = (rd_ptr != cm_ptr);
  assign out_data  = mem[rd_ptr[AW-1:0]][31:0];
  assign out_last  = mem[rd_ptr[AW-1:0]][32];
  assign rd_xfer   = out_valid && out_ready;

`ifdef VMON_MSG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  assign to_hit = (state != IDLE) && !in_valid && (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                to_cnt <= '0;
    else if (state == IDLE || in_valid || to_hit) to_cnt <= '0;
    else                                         to_cnt <= to_cnt + 1'b1;
  end
`else
  logic unused_timeout;
  assign to_hit         = 1'b0;
  assign unused_timeout = |TIMEOUT;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid && len != 16'd0) state_nxt = hdr_fits ? PAYLOAD : DROP;
      PAYLOAD: if (in_valid && rem == 16'd1) state_nxt = IDLE;
      DROP:    if (in_valid && rem == 16'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (to_hit) state_nxt = IDLE;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_en    = 1'b0;
    wr_last  = 1'b0;
    commit   = 1'b0;
    drop_inc = 1'b0;
    load_rem = 1'b0;
    rollback = to_hit;
    busy_o   = (state != IDLE);
    case (state)
      IDLE: if (in_valid) begin
        load_rem = 1'b1;
        if (hdr_fits) begin
          wr_en   = 1'b1;
          wr_last = (len == 16'd0);
          commit  = (len == 16'd0);
        end else begin
          drop_inc = 1'b1;
        end
      end
      PAYLOAD: if (in_valid) begin
        wr_en   = 1'b1;
        wr_last = (rem == 16'd1);
        commit  = (rem == 16'd1);
      end
      default: ;
    endcase
    // A DROP timeout was already counted when its header was rejected.
    if (to_hit && state == PAYLOAD) drop_inc = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr   <= '0;
      cm_ptr   <= '0;
      rd_ptr   <= '0;
      rem      <= '0;
      drop_cnt <= '0;
    end else begin
      if (rollback)   wr_ptr <= cm_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (commit)  cm_ptr <= wr_ptr + 1'b1;
      if (rd_xfer) rd_ptr <= rd_ptr + 1'b1;
      if (load_rem)                        rem <= len;
      else if (in_valid && state != IDLE)  rem <= rem - 16'd1;
      if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // NOTE: storage array has no reset; pointers alone define which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {wr_last, in_data};
  end

endmodule

// File: tb/tb_wb_vmon_msg_assembler.sv
// Self-checking bench for wb_vmon_msg_assembler: vector table, directed corner
// sequences, then randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_wb_vmon_msg_assembler;

  localparam int DEPTH   = 64;
  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 1024;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy_o;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  wb_vmon_msg_assembler #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy_o(busy_o), .drop_cnt(drop_cnt)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic        eb;
    logic [15:0] edrop;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } word_t;

  // Reference model: committed words, words of the message being built, words still expected.
  word_t cq[$];
  word_t pq[$];
  int    m_rem;
  bit    m_drop;
  int    m_drops;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic r);
    @(negedge clk_i);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    rst_n_i   = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    cq.delete();
    pq.delete();
    m_rem   = 0;
    m_drop  = 1'b0;
    m_drops = 0;
  endtask

  task automatic model_update(input logic v, input logic [31:0] d, input logic r);
    int free;
    int len;
    free = DEPTH - (cq.size() + pq.size());
    if (cq.size() > 0 && r) void'(cq.pop_front());
    if (!v) return;
    if (m_rem == 0) begin
      len = int'(d[15:0]);
      if (len > MAX_LEN || len + 1 > free) begin
        if (m_drops < 65535) m_drops++;
        m_rem  = len;
        m_drop = 1'b1;
      end else if (len == 0) begin
        cq.push_back('{d, 1'b1});
      end else begin
        pq.push_back('{d, 1'b0});
        m_rem  = len;
        m_drop = 1'b0;
      end
    end else begin
      m_rem--;
      if (!m_drop) begin
        pq.push_back('{d, m_rem == 0});
        if (m_rem == 0) begin
          foreach (pq[i]) cq.push_back(pq[i]);
          pq.delete();
        end
      end
    end
  endtask

  vec_t vecs[9];

  initial begin
    int          n_last;
    logic [31:0] exp_w;
    logic [31:0] tmp;
    int          rpct;
    int          len;
    logic        v;
    logic        r;
    logic [31:0] d;

    rst_n_i   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    vecs = '{
      '{1'b1, 32'h0100_0002, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 16'd0},
      '{1'b1, 32'h0000_000A, 1'b1, 1'b0, 32'h0,          1'b0, 1'b1, 16'd0},
      '{1'b1, 32'h0000_000B, 1'b1, 1'b0, 32'h0,          1'b0, 1'b1, 16'd0},
      '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0100_0002, 1'b0, 1'b0, 16'd0},
      '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_000A, 1'b0, 1'b0, 16'd0},
      '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_000B, 1'b1, 1'b0, 16'd0},
      '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 16'd0},
      '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 16'd0},
      '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,          1'b0, 1'b0, 16'd0}
    };

    // Reset state
    do_reset();
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_busy", busy_o, 1'b0);
    check("reset_drop_cnt", drop_cnt, 16'd0);

    // Basic message and zero-length message
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].rdy);
      check($sformatf("vec%0d_valid", i), out_valid, vecs[i].ev);
      check($sformatf("vec%0d_busy", i), busy_o, vecs[i].eb);
      check($sformatf("vec%0d_drop", i), drop_cnt, vecs[i].edrop);
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_data", i), out_data, vecs[i].ed);
        check($sformatf("vec%0d_last", i), out_last, vecs[i].el);
      end
    end

    // Fill: 21 len-2 messages fit in 63 words, the 22nd is dropped
    do_reset();
    for (int m = 0; m < 22; m++) begin
      drive(1'b1, {16'(m), 16'd2}, 1'b0);
      drive(1'b1, 32'(m * 16 + 1), 1'b0);
      drive(1'b1, 32'(m * 16 + 2), 1'b0);
    end
    drive(1'b0, 32'h0, 1'b0);
    check("fill_drop_cnt", drop_cnt, 16'd1);
    check("fill_busy", busy_o, 1'b0);
    check("fill_head", out_data, 32'h0000_0002);
    drive(1'b0, 32'h0, 1'b0);
    check("fill_head_stable", out_data, 32'h0000_0002);
    check("fill_head_valid", out_valid, 1'b1);
    n_last = 0;
    for (int k = 0; k < 63; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      case (k % 3)
        0:       exp_w = {16'(k / 3), 16'd2};
        1:       exp_w = 32'((k / 3) * 16 + 1);
        default: exp_w = 32'((k / 3) * 16 + 2);
      endcase
      check($sformatf("drain%0d_valid", k), out_valid, 1'b1);
      check($sformatf("drain%0d_data", k), out_data, exp_w);
      check($sformatf("drain%0d_last", k), out_last, (k % 3) == 2);
      if (out_valid && out_last) n_last++;
    end
    drive(1'b0, 32'h0, 1'b1);
    check("drain_empty", out_valid, 1'b0);
    check("drain_last_count", n_last, 21);

    // Oversized header: message swallowed, next message intact
    do_reset();
    drive(1'b1, 32'h0000_0011, 1'b1);
    check("big_hdr_busy", busy_o, 1'b0);
    for (int k = 0; k < 17; k++) begin
      tmp = $urandom;
      drive(1'b1, tmp, 1'b1);
      check($sformatf("big%0d_busy", k), busy_o, 1'b1);
      check($sformatf("big%0d_valid", k), out_valid, 1'b0);
    end
    drive(1'b1, 32'h1234_0001, 1'b1);
    check("big_after_busy", busy_o, 1'b0);
    check("big_after_valid", out_valid, 1'b0);
    check("big_drop_cnt", drop_cnt, 16'd1);
    drive(1'b1, 32'h0000_CAFE, 1'b1);
    check("small_busy", busy_o, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    check("small_hdr_data", out_data, 32'h1234_0001);
    check("small_hdr_last", out_last, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    check("small_pay_data", out_data, 32'h0000_CAFE);
    check("small_pay_last", out_last, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    check("small_empty", out_valid, 1'b0);

    // Asynchronous reset in the middle of a message
    do_reset();
    drive(1'b1, 32'h0000_0000, 1'b0);
    drive(1'b1, 32'h0000_0014, 1'b0);
    for (int k = 0; k < 20; k++) drive(1'b1, 32'(k), 1'b0);
    drive(1'b1, 32'h0000_0003, 1'b0);
    drive(1'b1, 32'h0000_0077, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    check("prerst_valid", out_valid, 1'b1);
    check("prerst_drop", drop_cnt, 16'd1);
    check("prerst_busy", busy_o, 1'b1);
    #2 rst_n_i = 1'b0;
    #1;
    check("asyncrst_valid", out_valid, 1'b0);
    check("asyncrst_drop", drop_cnt, 16'd0);
    check("asyncrst_busy", busy_o, 1'b0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    drive(1'b1, 32'hBEEF_0002, 1'b1);
    drive(1'b1, 32'h0000_0011, 1'b1);
    drive(1'b1, 32'h0000_0022, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    check("postrst_hdr", out_data, 32'hBEEF_0002);
    check("postrst_hdr_last", out_last, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    check("postrst_w1", out_data, 32'h0000_0011);
    drive(1'b0, 32'h0, 1'b1);
    check("postrst_w2", out_data, 32'h0000_0022);
    check("postrst_w2_last", out_last, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    check("postrst_empty", out_valid, 1'b0);

    // Long idle gap inside a message
    do_reset();
    drive(1'b1, 32'h0000_0004, 1'b1);
    drive(1'b1, 32'h0000_0001, 1'b1);
    drive(1'b1, 32'h0000_0002, 1'b1);
    for (int k = 0; k < TIMEOUT; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      if (k == TIMEOUT - 1) check("idle_busy_before_limit", busy_o, 1'b1);
    end
    drive(1'b0, 32'h0, 1'b1);
    check("idle_valid", out_valid, 1'b0);
`ifdef VMON_MSG_TIMEOUT_EN
    check("timeout_busy", busy_o, 1'b0);
    check("timeout_drop", drop_cnt, 16'd1);
    drive(1'b1, 32'h5555_0001, 1'b1);
    drive(1'b1, 32'h0000_0099, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    check("timeout_next_hdr", out_data, 32'h5555_0001);
    check("timeout_next_valid", out_valid, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    check("timeout_next_pay", out_data, 32'h0000_0099);
    check("timeout_next_last", out_last, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    check("timeout_next_empty", out_valid, 1'b0);
`else
    check("wait_busy", busy_o, 1'b1);
    check("wait_drop", drop_cnt, 16'd0);
    drive(1'b1, 32'h0000_0003, 1'b1);
    drive(1'b1, 32'h0000_0004, 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      exp_w = (k == 0) ? 32'h0000_0004 : 32'(k);
      check($sformatf("wait_out%0d_data", k), out_data, exp_w);
      check($sformatf("wait_out%0d_last", k), out_last, k == 4);
    end
    drive(1'b0, 32'h0, 1'b1);
    check("wait_empty", out_valid, 1'b0);
`endif

    // Randomized traffic against the reference model
    do_reset();
    rpct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        case ($urandom_range(0, 2))
          0:       rpct = 5;
          1:       rpct = 50;
          default: rpct = 95;
        endcase
      end
      v   = ($urandom_range(0, 99) < 65);
      r   = ($urandom_range(0, 99) < rpct);
      tmp = $urandom;
      if (m_rem == 0) begin
        len = ($urandom_range(0, 9) == 0) ? $urandom_range(17, 20) : $urandom_range(0, MAX_LEN);
        d   = {tmp[31:16], 16'(len)};
      end else begin
        d = tmp;
      end
      @(negedge clk_i);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      check("rnd_busy", busy_o, m_rem > 0);
      check("rnd_valid", out_valid, cq.size() > 0);
      check("rnd_drop", drop_cnt, 16'(m_drops));
      if (cq.size() > 0) begin
        check("rnd_data", out_data, cq[0].d);
        check("rnd_last", out_last, cq[0].l);
      end
      model_update(v, d, r);
    end

    @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
